time_set_ctrl: RTL and testbench

- Time-setting controller for the 6-digit HH:MM:SS digital clock.
- Sequences the user through hour, minute and second edit fields from two debounced keys, and holds the edit values in shadow registers.
- On commit, issues a one-cycle parallel load into the time counter.
- Pauses the counter during editing and drives per-digit blink masks to the display scan/segment logic.

---
 rtl/time_set_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-setting controller for an HH:MM:SS clock.
//
// Two debounced keys walk the user through hour, minute and second edit fields. The values
// being edited live in shadow registers (set_*). A mode press in the seconds field commits them
// with a one-cycle load pulse. The live counter is paused while editing. An idle timeout
// abandons the edit without loading.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   key_mode, key_inc   debounced key levels, 1 = pressed
//   cur_hour/min/sec    live counter value, copied into the shadow on edit entry
//   set_hour/min/sec    shadow value being edited
//   load                one-cycle pulse; the counter loads set_*
//   run_en              counter count enable, low while editing or committing
//   edit_field          0 = none, 1 = hour, 2 = min, 3 = sec
//   blink_mask          1 = blank digit; [5:4] hour, [3:2] min, [1:0] sec
module time_set_ctrl #(
  parameter int unsigned BLINK_HALF  = 12_500_000,
  parameter int unsigned HOLD_CNT    = 25_000_000,
  parameter int unsigned REPEAT_CNT  = 5_000_000,
  parameter int unsigned TIMEOUT_CNT = 500_000_000,
  parameter int unsigned CW          = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load,
  output logic       run_en,
  output logic [1:0] edit_field,
  output logic [5:0] blink_mask
);

  typedef enum logic [2:0] {StRun, StEditHour, StEditMin, StEditSec, StCommit} state_e;

  // Counters run from 0 and act when they sit at limit-1, so an event lands exactly N
  // cycles after its reference edge.
  localparam logic [CW-1:0] BlinkLim   = CW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] HoldLim    = CW'(HOLD_CNT - 1);
  localparam logic [CW-1:0] RepeatLim  = CW'(REPEAT_CNT - 1);
  localparam logic [CW-1:0] TimeoutLim = CW'(TIMEOUT_CNT - 1);

  state_e          state_q, state_d;
  logic            mode_prev_q, inc_prev_q;
  logic [4:0]      set_hour_q, set_hour_d;
  logic [5:0]      set_min_q, set_min_d;
  logic [5:0]      set_sec_q, set_sec_d;
  logic            hold_active_q, hold_active_d;
  logic            repeating_q, repeating_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            load_q, load_d;
  logic            run_en_q, run_en_d;
  logic [1:0]      edit_field_q, edit_field_d;
  logic [5:0]      blink_mask_q, blink_mask_d;

  logic            mode_press, inc_press, in_edit, next_edit, step;
  logic [CW-1:0]   hold_lim;

  assign mode_press = key_mode & ~mode_prev_q;
  assign inc_press  = key_inc & ~inc_prev_q;
  assign in_edit    = (state_q == StEditHour) || (state_q == StEditMin) ||
                      (state_q == StEditSec);
  assign hold_lim   = repeating_q ? RepeatLim : HoldLim;

  always_comb begin
    state_d       = state_q;
    set_hour_d    = set_hour_q;
    set_min_d     = set_min_q;
    set_sec_d     = set_sec_q;
    hold_active_d = hold_active_q;
    repeating_d   = repeating_q;
    hold_cnt_d    = hold_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    step          = 1'b0;
    next_edit     = 1'b0;
    load_d        = 1'b0;
    run_en_d      = 1'b0;
    edit_field_d  = 2'd0;
    blink_mask_d  = 6'd0;

    unique case (state_q)
      StRun: begin
        if (mode_press) begin
          state_d    = StEditHour;
          set_hour_d = cur_hour;
          set_min_d  = cur_min;
          set_sec_d  = cur_sec;
        end
      end
      StEditHour: if (mode_press) state_d = StEditMin;
      StEditMin:  if (mode_press) state_d = StEditSec;
      StEditSec:  if (mode_press) state_d = StCommit;
      StCommit:   state_d = StRun;
      default:    state_d = StRun;
    endcase

    if (in_edit) begin
      // Mode wins over inc and cancels any hold until inc is released and re-pressed.
      if (mode_press) begin
        hold_active_d = 1'b0;
        repeating_d   = 1'b0;
        hold_cnt_d    = '0;
      end else if (inc_press) begin
        step          = 1'b1;
        hold_active_d = 1'b1;
        repeating_d   = 1'b0;
        hold_cnt_d    = '0;
      end else if (hold_active_q && key_inc) begin
        if (hold_cnt_q == hold_lim) begin
          step        = 1'b1;
          repeating_d = 1'b1;
          hold_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end else begin
        hold_active_d = 1'b0;
        repeating_d   = 1'b0;
        hold_cnt_d    = '0;
      end

      if (mode_press || step) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == TimeoutLim) begin
        idle_cnt_d = '0;
        state_d    = StRun;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      hold_active_d = 1'b0;
      repeating_d   = 1'b0;
      hold_cnt_d    = '0;
      idle_cnt_d    = '0;
    end

    if (step) begin
      case (state_q)
        StEditHour: set_hour_d = (set_hour_q >= 5'd23) ? 5'd0 : set_hour_q + 5'd1;
        StEditMin:  set_min_d  = (set_min_q  >= 6'd59) ? 6'd0 : set_min_q  + 6'd1;
        StEditSec:  set_sec_d  = (set_sec_q  >= 6'd59) ? 6'd0 : set_sec_q  + 6'd1;
        default: ;
      endcase
    end

    next_edit = (state_d == StEditHour) || (state_d == StEditMin) || (state_d == StEditSec);

    // Digits are forced visible on field entry and on every step, so the user sees the result.
    if (!next_edit || (state_d != state_q) || step) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BlinkLim) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    // Outputs are registered from next-state values so they line up with state_q.
    load_d   = (state_d == StCommit);
    run_en_d = (state_d == StRun);
    unique case (state_d)
      StEditHour: begin
        edit_field_d = 2'd1;
        blink_mask_d = {{2{blink_phase_d}}, 4'b0000};
      end
      StEditMin: begin
        edit_field_d = 2'd2;
        blink_mask_d = {2'b00, {2{blink_phase_d}}, 2'b00};
      end
      StEditSec: begin
        edit_field_d = 2'd3;
        blink_mask_d = {4'b0000, {2{blink_phase_d}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      // Start "pressed" so a key held through reset is not taken as a fresh press.
      mode_prev_q   <= 1'b1;
      inc_prev_q    <= 1'b1;
      set_hour_q    <= '0;
      set_min_q     <= '0;
      set_sec_q     <= '0;
      hold_active_q <= 1'b0;
      repeating_q   <= 1'b0;
      hold_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      load_q        <= 1'b0;
      run_en_q      <= 1'b1;
      edit_field_q  <= 2'd0;
      blink_mask_q  <= 6'd0;
    end else begin
      state_q       <= state_d;
      mode_prev_q   <= key_mode;
      inc_prev_q    <= key_inc;
      set_hour_q    <= set_hour_d;
      set_min_q     <= set_min_d;
      set_sec_q     <= set_sec_d;
      hold_active_q <= hold_active_d;
      repeating_q   <= repeating_d;
      hold_cnt_q    <= hold_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      load_q        <= load_d;
      run_en_q      <= run_en_d;
      edit_field_q  <= edit_field_d;
      blink_mask_q  <= blink_mask_d;
    end
  end

  assign set_hour   = set_hour_q;
  assign set_min    = set_min_q;
  assign set_sec    = set_sec_q;
  assign load       = load_q;
  assign run_en     = run_en_q;
  assign edit_field = edit_field_q;
  assign blink_mask = blink_mask_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus a randomized run, all checked against a
// cycle-count reference model (elapsed cycles since press / activity / blink restart).
module tb_time_set_ctrl;

  localparam int BH = 4;
  localparam int HC = 10;
  localparam int RC = 3;
  localparam int TC = 50;

  logic       clk = 1'b0;
  logic       rst, key_mode, key_inc;
  logic [4:0] cur_hour;
  logic [5:0] cur_min, cur_sec;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       load, run_en;
  logic [1:0] edit_field;
  logic [5:0] blink_mask;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: mode 0 = run, 1..3 = editing hour/min/sec, 4 = commit.
  int m_mode = 0, m_hour = 0, m_min = 0, m_sec = 0;
  int m_held = -1, m_idle = 0, m_age = 0;
  bit m_pm = 1'b1, m_pi = 1'b1;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .BLINK_HALF (BH),
    .HOLD_CNT   (HC),
    .REPEAT_CNT (RC),
    .TIMEOUT_CNT(TC),
    .CW         (29)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .load      (load),
    .run_en    (run_en),
    .edit_field(edit_field),
    .blink_mask(blink_mask)
  );

  function automatic void model_edge();
    bit mp, ip, stp;
    if (rst) begin
      m_mode = 0; m_hour = 0; m_min = 0; m_sec = 0;
      m_pm = 1'b1; m_pi = 1'b1; m_held = -1; m_idle = 0; m_age = 0;
      return;
    end
    mp = key_mode && !m_pm;
    ip = key_inc && !m_pi;
    m_pm = key_mode;
    m_pi = key_inc;
    stp = 1'b0;
    if (m_mode == 0) begin
      if (mp) begin
        m_mode = 1; m_hour = int'(cur_hour); m_min = int'(cur_min); m_sec = int'(cur_sec);
        m_held = -1; m_idle = 0; m_age = 0;
      end
    end else if (m_mode == 4) begin
      m_mode = 0;
    end else if (mp) begin
      m_mode = m_mode + 1; m_held = -1; m_idle = 0; m_age = 0;
    end else begin
      if (ip) begin
        stp = 1'b1; m_held = 0;
      end else if (m_held >= 0 && key_inc) begin
        m_held = m_held + 1;
        if (m_held == HC || (m_held > HC && (m_held - HC) % RC == 0)) stp = 1'b1;
      end else begin
        m_held = -1;
      end
      if (stp) begin
        if (m_mode == 1) m_hour = (m_hour + 1) % 24;
        else if (m_mode == 2) m_min = (m_min + 1) % 60;
        else m_sec = (m_sec + 1) % 60;
        m_idle = 0; m_age = 0;
      end else begin
        m_idle = m_idle + 1; m_age = m_age + 1;
        if (m_idle == TC) begin m_mode = 0; m_held = -1; end
      end
    end
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [1:0] f;
    logic [5:0] mk;
    f  = (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
    mk = 6'd0;
    if ((m_age / BH) % 2 == 1) begin
      case (f)
        2'd1: mk = 6'b110000;
        2'd2: mk = 6'b001100;
        2'd3: mk = 6'b000011;
        default: mk = 6'd0;
      endcase
    end
    return {5'(m_hour), 6'(m_min), 6'(m_sec), 1'(m_mode == 4), 1'(m_mode == 0), f, mk};
  endfunction

  // Advance one clock with the model in lock-step; outputs are stable #1 after the edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    key_mode = 1'b1; cycle();
    key_mode = 1'b0; cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_mode = 1'b1; key_inc = 1'b0;
    cur_hour = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
    repeat (3) cycle();
    n_cmp++;
    if ({load, run_en, edit_field, blink_mask, set_hour, set_min, set_sec} !== 27'h2000000) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h",
               {load, run_en, edit_field, blink_mask, set_hour, set_min, set_sec}, 27'h2000000);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (edit_field !== 2'd0 || run_en !== 1'b1) begin
        n_fail++;
        $display("FAIL held_key_after_reset: field %0d run_en %0d want 0 1", edit_field, run_en);
      end
    end
    key_mode = 1'b0; cycle();
  endtask

  task automatic test_entry();
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    key_mode = 1'b1; cycle();
    key_mode = 1'b0;
    n_cmp++;
    if (edit_field !== 2'd1 || run_en !== 1'b0 ||
        {set_hour, set_min, set_sec} !== {5'd12, 6'd34, 6'd56}) begin
      n_fail++;
      $display("FAIL entry: field %0d run_en %0d set %0d:%0d:%0d want 1 0 12:34:56",
               edit_field, run_en, set_hour, set_min, set_sec);
    end
    for (int i = 0; i < 12; i++) begin
      logic [5:0] want;
      want = ((i / BH) % 2 == 1) ? 6'b110000 : 6'b000000;
      n_cmp++;
      if (blink_mask !== want) begin
        n_fail++;
        $display("FAIL entry_blink[%0d]: got %b want %b", i, blink_mask, want);
      end
      cycle();
    end
    repeat (3) press_mode();
  endtask

  task automatic test_wrap_commit();
    int loads;
    logic [4:0] hour_at_load;
    cur_hour = 5'd22;
    press_mode();
    key_inc = 1'b1; cycle();
    n_cmp++;
    if (set_hour !== 5'd23) begin
      n_fail++; $display("FAIL hour_step_23: got %0d want 23", set_hour);
    end
    key_inc = 1'b0; cycle();
    key_inc = 1'b1; cycle();
    n_cmp++;
    if (set_hour !== 5'd0) begin
      n_fail++; $display("FAIL hour_wrap_0: got %0d want 0", set_hour);
    end
    key_inc = 1'b0; cycle();
    loads = 0; hour_at_load = 5'd31;
    for (int p = 0; p < 3; p++) begin
      key_mode = 1'b1; cycle();
      if (load) begin loads++; hour_at_load = set_hour; end
      key_mode = 1'b0; cycle();
      if (load) begin loads++; hour_at_load = set_hour; end
    end
    repeat (3) begin
      cycle();
      if (load) loads++;
    end
    n_cmp++;
    if (loads != 1 || hour_at_load !== 5'd0) begin
      n_fail++;
      $display("FAIL commit_load: pulses %0d hour %0d want 1 pulse hour 0", loads, hour_at_load);
    end
    n_cmp++;
    if (run_en !== 1'b1 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL after_commit: run_en %0d field %0d want 1 0", run_en, edit_field);
    end
  endtask

  task automatic test_auto_repeat();
    cur_min = 6'd58;
    press_mode();
    press_mode();
    n_cmp++;
    if (edit_field !== 2'd2 || set_min !== 6'd58) begin
      n_fail++;
      $display("FAIL repeat_setup: field %0d min %0d want 2 58", edit_field, set_min);
    end
    key_inc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int steps;
      cycle();
      steps = 1 + ((i >= HC) ? 1 + (i - HC) / RC : 0);
      n_cmp++;
      if (int'(set_min) != (58 + steps) % 60) begin
        n_fail++;
        $display("FAIL repeat_min[%0d]: got %0d want %0d", i, set_min, (58 + steps) % 60);
      end
    end
    key_inc = 1'b0; cycle();
    press_mode();
    press_mode();
    cycle();
  endtask

  task automatic test_timeout();
    int loads;
    press_mode();
    press_mode();
    key_mode = 1'b1; cycle();
    key_mode = 1'b0;
    loads = 0;
    for (int i = 1; i <= TC; i++) begin
      cycle();
      if (load) loads++;
      if (i == TC - 1) begin
        n_cmp++;
        if (edit_field !== 2'd3) begin
          n_fail++; $display("FAIL timeout_early: field %0d want 3 at cycle %0d", edit_field, i);
        end
      end
    end
    n_cmp++;
    if (edit_field !== 2'd0 || run_en !== 1'b1 || loads != 0) begin
      n_fail++;
      $display("FAIL timeout_exit: field %0d run_en %0d loads %0d want 0 1 0",
               edit_field, run_en, loads);
    end
    cycle();
    n_cmp++;
    if (load !== 1'b0) begin
      n_fail++; $display("FAIL timeout_no_load: got %0d want 0", load);
    end
  endtask

  task automatic test_simultaneous();
    int want_h, want_m;
    press_mode();
    want_h = m_hour;
    key_mode = 1'b1; key_inc = 1'b1; cycle();
    key_mode = 1'b0;
    n_cmp++;
    if (edit_field !== 2'd2 || int'(set_hour) != want_h) begin
      n_fail++;
      $display("FAIL simultaneous: field %0d hour %0d want 2 %0d", edit_field, set_hour, want_h);
    end
    want_m = m_min;
    repeat (15) cycle();
    n_cmp++;
    if (int'(set_min) != want_m) begin
      n_fail++; $display("FAIL no_repeat_armed: min %0d want %0d", set_min, want_m);
    end
    key_inc = 1'b0; cycle();
    press_mode();
    press_mode();
    cycle();
  endtask

  task automatic test_reset_mid();
    int loads;
    press_mode();
    press_mode();
    rst = 1'b1; key_mode = 1'b1; cycle();
    loads = int'(load);
    cycle();
    loads += int'(load);
    n_cmp++;
    if ({load, run_en, edit_field, blink_mask, set_hour, set_min, set_sec} !== 27'h2000000 ||
        loads != 0) begin
      n_fail++;
      $display("FAIL reset_mid_edit: got %h loads %0d want %h 0",
               {load, run_en, edit_field, blink_mask, set_hour, set_min, set_sec}, loads,
               27'h2000000);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (edit_field !== 2'd0 || load !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_held_mode[%0d]: field %0d load %0d want 0 0", i, edit_field, load);
      end
    end
    key_mode = 1'b0; cycle();
    key_mode = 1'b1; cycle();
    n_cmp++;
    if (edit_field !== 2'd1) begin
      n_fail++; $display("FAIL repress_after_reset: field %0d want 1", edit_field);
    end
    key_mode = 1'b0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) key_mode = ~key_mode;
      if ($urandom_range(7) == 0) key_inc = ~key_inc;
      rst = ($urandom_range(299) == 0);
      cur_hour = 5'($urandom_range(23));
      cur_min  = 6'($urandom_range(59));
      cur_sec  = 6'($urandom_range(59));
      cycle();
      n_cmp++;
      if ({set_hour, set_min, set_sec, load, run_en, edit_field, blink_mask} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i,
                 {set_hour, set_min, set_sec, load, run_en, edit_field, blink_mask}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_wrap_commit();
    test_auto_repeat();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
